// File: rtl/bus_cmp_pkg.sv
// Shared encodings for the redundant-channel bus comparator.
// Holds the FSM state encoding, the switch pattern length and the safe output levels.
package bus_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_RUN   = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam int PATTERN_LEN = 16;
    localparam int PHASE_W     = $clog2(PATTERN_LEN);

    localparam logic SAFE_RELAY  = 1'b0;
    localparam logic SAFE_SWITCH = 1'b0;

    // Role 0 pulses on phase 0 only; role 1 is high for every other phase.
    function automatic logic switch_level(input logic role, input logic [PHASE_W-1:0] phase);
        return role ? (phase != '0) : (phase == '0);
    endfunction

endpackage

// File: rtl/bus_cmp_pattern_gen.sv
// Phase counter and relay/switch encoding for one redundant instance.
// Outputs are registered and restart at phase 0 whenever run is low.
module bus_cmp_pattern_gen
    import bus_cmp_pkg::*;
#(
    parameter int ROLE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic relayCtrl,
    output logic switchCtrl
);

    localparam logic ROLE_BIT = (ROLE != 0);

    logic               r_active;
    logic [PHASE_W-1:0] r_phase;
    logic               r_relay;
    logic               r_switch;
    logic [PHASE_W-1:0] w_phase_next;

    // The first active cycle shows phase 0; later ones advance and wrap.
    always_comb begin
        w_phase_next = '0;
        if (r_active && (r_phase != PHASE_W'(PATTERN_LEN - 1))) begin
            w_phase_next = r_phase + PHASE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            r_active <= 1'b0;
            r_phase  <= '0;
            r_relay  <= SAFE_RELAY;
            r_switch <= SAFE_SWITCH;
        end else begin
            r_active <= 1'b1;
            r_phase  <= w_phase_next;
            r_relay  <= ROLE_BIT ^ w_phase_next[0];
            r_switch <= switch_level(ROLE_BIT, w_phase_next);
        end
    end

    assign relayCtrl  = r_relay;
    assign switchCtrl = r_switch;

endmodule

// File: rtl/bus_compare_driver.sv
// Redundant-channel bus comparator: classifies A/B samples, qualifies agreement,
// and drives the dynamic relay/switch signals while running; any fault freezes them safe.
module bus_compare_driver
    import bus_cmp_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int ROLE      = 0,
    parameter int ARM_COUNT = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] busA,
    input  logic             validA,
    input  logic [WIDTH-1:0] busB,
    input  logic             validB,
    output logic             relayCtrl,
    output logic             switchCtrl,
    output logic [1:0]       state,
    output logic             fault
);

    localparam logic [3:0] ARM_TGT     = 4'(ARM_COUNT);
    localparam logic [7:0] TIMEOUT_TGT = 8'(TIMEOUT);
    localparam logic       DIRECT_RUN  = (ARM_COUNT == 1);

    state_t     r_state;
    logic [3:0] r_arm_cnt;
    logic [7:0] r_gap_cnt;

    logic       w_both;
    logic       w_match;
    logic       w_mismatch;
    logic       w_none;
    logic [3:0] w_arm_inc;
    logic [7:0] w_gap_inc;
    logic       w_arm_done;
    logic       w_timeout;
    logic       w_run_next;

    assign w_both     = validA && validB;
    assign w_match    = w_both && (busA == busB);
    assign w_mismatch = (w_both && (busA != busB)) || (validA ^ validB);
    assign w_none     = !validA && !validB;

    // Counters saturate rather than wrap.
    assign w_arm_inc  = (r_arm_cnt == 4'hF) ? r_arm_cnt : r_arm_cnt + 4'd1;
    assign w_gap_inc  = (r_gap_cnt == 8'hFF) ? r_gap_cnt : r_gap_cnt + 8'd1;
    assign w_arm_done = (w_arm_inc >= ARM_TGT);
    assign w_timeout  = w_none && (w_gap_inc >= TIMEOUT_TGT);

    // Next-cycle RUN qualifier lets the pattern generator update on the same edge as the FSM.
    always_comb begin
        w_run_next = 1'b0;
        case (r_state)
            ST_IDLE: w_run_next = w_match && DIRECT_RUN;
            ST_ARM:  w_run_next = w_match && w_arm_done;
            ST_RUN:  w_run_next = !w_mismatch && !w_timeout;
            default: w_run_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_arm_cnt <= 4'd0;
            r_gap_cnt <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        r_gap_cnt <= 8'd0;
                        if (DIRECT_RUN) begin
                            r_state   <= ST_RUN;
                            r_arm_cnt <= 4'd0;
                        end else begin
                            r_state   <= ST_ARM;
                            r_arm_cnt <= 4'd1;
                        end
                    end
                end
                ST_ARM: begin
                    if (w_mismatch) begin
                        r_state   <= ST_IDLE;
                        r_arm_cnt <= 4'd0;
                    end else if (w_match) begin
                        if (w_arm_done) begin
                            r_state   <= ST_RUN;
                            r_arm_cnt <= 4'd0;
                            r_gap_cnt <= 8'd0;
                        end else begin
                            r_arm_cnt <= w_arm_inc;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_mismatch || w_timeout) begin
                        r_state <= ST_FAULT;
                    end else if (w_match) begin
                        r_gap_cnt <= 8'd0;
                    end else begin
                        r_gap_cnt <= w_gap_inc;
                    end
                end
                default: r_state <= ST_FAULT;
            endcase
        end
    end

    bus_cmp_pattern_gen #(
        .ROLE(ROLE)
    ) u_pattern (
        .clk        (clk),
        .rst        (rst),
        .run        (w_run_next),
        .relayCtrl  (relayCtrl),
        .switchCtrl (switchCtrl)
    );

    assign state = r_state;
    assign fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_bus_compare_driver.sv
// Lockstep ROLE 0 / ROLE 1 bench: a behavioural model pushes expected outputs
// to a scoreboard queue on every driven cycle; each test pops and compares.
module tb_bus_compare_driver;

    localparam int ARM_COUNT = 4;
    localparam int TIMEOUT   = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] busA, busB;
    logic        validA, validB;
    logic        relay0, sw0, f0, relay1, sw1, f1;
    logic [1:0]  st0, st1;
    logic [9:0]  w_got;

    int checks = 0;
    int errors = 0;

    logic [9:0] sb_q[$];

    int m_state = 0;
    int m_arm   = 0;
    int m_gap   = 0;
    int m_phase = 0;

    always #5 clk = ~clk;

    bus_compare_driver #(.WIDTH(16), .ROLE(0), .ARM_COUNT(ARM_COUNT), .TIMEOUT(TIMEOUT)) dut0 (
        .clk(clk), .rst(rst), .busA(busA), .validA(validA), .busB(busB), .validB(validB),
        .relayCtrl(relay0), .switchCtrl(sw0), .state(st0), .fault(f0));

    bus_compare_driver #(.WIDTH(16), .ROLE(1), .ARM_COUNT(ARM_COUNT), .TIMEOUT(TIMEOUT)) dut1 (
        .clk(clk), .rst(rst), .busA(busA), .validA(validA), .busB(busB), .validB(validB),
        .relayCtrl(relay1), .switchCtrl(sw1), .state(st1), .fault(f1));

    assign w_got = {st0, f0, relay0, sw0, st1, f1, relay1, sw1};

    task automatic model_push(input logic r, input logic [15:0] a, input logic va,
                              input logic [15:0] b, input logic vb);
        int  ns;
        bit  match, mism;
        logic rl0, rl1, s0, s1, f;
        match = va && vb && (a == b);
        mism  = (va && vb && (a != b)) || (va ^ vb);
        ns    = m_state;
        if (r) begin
            ns = 0; m_arm = 0; m_gap = 0;
        end else begin
            case (m_state)
                0: if (match) begin
                       m_gap = 0;
                       if (ARM_COUNT == 1) ns = 2;
                       else begin ns = 1; m_arm = 1; end
                   end
                1: if (mism) begin
                       ns = 0; m_arm = 0;
                   end else if (match) begin
                       m_arm++;
                       if (m_arm >= ARM_COUNT) begin ns = 2; m_gap = 0; end
                   end
                2: if (mism) ns = 3;
                   else if (match) m_gap = 0;
                   else begin
                       m_gap++;
                       if (m_gap >= TIMEOUT) ns = 3;
                   end
                default: ns = 3;
            endcase
        end
        if (ns == 2) m_phase = (m_state == 2) ? (m_phase + 1) % 16 : 0;
        else         m_phase = 0;
        rl0 = (ns == 2) && (m_phase % 2 == 1);
        rl1 = (ns == 2) && (m_phase % 2 == 0);
        s0  = (ns == 2) && (m_phase == 0);
        s1  = (ns == 2) && (m_phase != 0);
        f   = (ns == 3);
        sb_q.push_back({2'(ns), f, rl0, s0, 2'(ns), f, rl1, s1});
        m_state = ns;
    endtask

    task automatic step(input logic r, input logic [15:0] a, input logic va,
                        input logic [15:0] b, input logic vb);
        rst = r; busA = a; validA = va; busB = b; validB = vb;
        model_push(r, a, va, b, vb);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] e;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e) begin errors++; $display("FAIL reset: got %b want %b", w_got, e); end
        end
        checks++;
        if (w_got !== 10'b0) begin errors++; $display("FAIL reset_zero: got %b want %b", w_got, 10'b0); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e) begin errors++; $display("FAIL idle_none: got %b want %b", w_got, e); end
        end
    endtask

    task automatic test_arm_run();
        logic [9:0] e;
        int pulses = 0;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e) begin errors++; $display("FAIL arm_seq[%0d]: got %b want %b", i, w_got, e); end
            checks++;
            if (st0 !== ((i < 3) ? 2'd1 : 2'd2)) begin
                errors++; $display("FAIL arm_state[%0d]: got %0d want %0d", i, st0, (i < 3) ? 1 : 2);
            end
        end
        checks++;
        if ({relay0, sw0, relay1, sw1} !== 4'b0110) begin
            errors++; $display("FAIL run_entry: got %b want %b", {relay0, sw0, relay1, sw1}, 4'b0110);
        end
        for (int k = 1; k <= 32; k++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e) begin errors++; $display("FAIL run_seq[%0d]: got %b want %b", k, w_got, e); end
            checks++;
            if (relay0 !== 1'(k % 2) || (relay0 ^ relay1) !== 1'b1 || sw1 !== ~sw0) begin
                errors++;
                $display("FAIL run_pattern[%0d]: got r0=%b r1=%b s0=%b s1=%b want r0=%0d xor=1 s1=~s0",
                         k, relay0, relay1, sw0, sw1, k % 2);
            end
            if (sw0 === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL pulse_count: got %0d want 2", pulses); end
    endtask

    task automatic test_arm_abort();
        logic [9:0] e;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            void'(sb_q.pop_front());
        end
        step(1'b0, 16'h1234, 1'b1, 16'h1235, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || st0 !== 2'd0) begin
            errors++; $display("FAIL abort_idle: got %b want %b", w_got, e);
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e || st0 !== ((i < 3) ? 2'd1 : 2'd2)) begin
                errors++; $display("FAIL rearm[%0d]: got %b want %b", i, w_got, e);
            end
        end
    endtask

    task automatic test_fault_valid();
        logic [9:0] e;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            void'(sb_q.pop_front());
        end
        step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b0);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || {st0, f0, relay0, sw0} !== 5'b11100) begin
            errors++; $display("FAIL fault_entry: got %b want %b", w_got, e);
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h1234, 1'b1, 16'h1234, 1'b1);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e || f0 !== 1'b1) begin
                errors++; $display("FAIL fault_sticky[%0d]: got %b want %b", i, w_got, e);
            end
        end
        step(1'b1, 16'h1234, 1'b1, 16'h1234, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || w_got !== 10'b0) begin
            errors++; $display("FAIL fault_reset: got %b want %b", w_got, e);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] e;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);
            void'(sb_q.pop_front());
        end
        for (int i = 1; i <= 62; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            void'(sb_q.pop_front());
        end
        step(1'b0, 16'hBEEF, 1'b1, 16'hBEEF, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || st0 !== 2'd2) begin
            errors++; $display("FAIL match_at_63: got %b want %b", w_got, e);
        end
        for (int i = 1; i <= 64; i++) begin
            step(1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e || st0 !== ((i < 64) ? 2'd2 : 2'd3)) begin
                errors++; $display("FAIL timeout[%0d]: got %b want %b", i, w_got, e);
            end
        end
    endtask

    task automatic test_rst_mid_run();
        logic [9:0] e;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 16'h00FF, 1'b1, 16'h00FF, 1'b1);
            void'(sb_q.pop_front());
        end
        checks++;
        if ({relay0, sw0, relay1, sw1} !== 4'b1001) begin
            errors++; $display("FAIL phase7: got %b want %b", {relay0, sw0, relay1, sw1}, 4'b1001);
        end
        step(1'b1, 16'h00FF, 1'b1, 16'h00FF, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || w_got !== 10'b0 || dut0.u_pattern.r_phase !== 4'd0) begin
            errors++; $display("FAIL rst_mid_run: got %b phase %0d want %b phase 0",
                               w_got, dut0.u_pattern.r_phase, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] e;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1);
            void'(sb_q.pop_front());
        end
        step(1'b0, 16'hA5A5, 1'b1, 16'h25A5, 1'b1);
        e = sb_q.pop_front(); checks++;
        if (w_got !== e || st0 !== 2'd3) begin
            errors++; $display("FAIL msb_mismatch: got %b want %b", w_got, e);
        end
    endtask

    task automatic test_random();
        logic [9:0] e;
        logic [15:0] a, b;
        logic va, vb, r;
        int kind;
        step(1'b1, 16'h0, 1'b0, 16'h0, 1'b0);
        void'(sb_q.pop_front());
        for (int i = 0; i < 400; i++) begin
            a = 16'($urandom); b = a; va = 1'b1; vb = 1'b1;
            kind = $urandom_range(0, 99);
            r = (m_state == 3) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 99) == 0);
            if (kind < 12) begin va = 1'b0; vb = 1'b0; end
            else if (kind < 15) b = a ^ (16'd1 << $urandom_range(0, 15));
            else if (kind < 17) vb = 1'b0;
            else if (kind < 19) va = 1'b0;
            step(r, a, va, b, vb);
            e = sb_q.pop_front(); checks++;
            if (w_got !== e) begin errors++; $display("FAIL random[%0d]: got %b want %b", i, w_got, e); end
        end
    endtask

    initial begin
        rst = 1'b1; busA = '0; busB = '0; validA = 1'b0; validB = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_arm_run();
        test_arm_abort();
        test_fault_valid();
        test_timeout();
        test_rst_mid_run();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
